// File: rtl/demux_1x2_tdm_pkg.sv
// Shared constants for the two-channel TDM receive demux.
package demux_1x2_tdm_pkg;
  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] EXP_B = 2'd1;
  localparam logic [1:0] EXP_A = 2'd2;
endpackage

// File: rtl/demux_1x2_tdm_if.sv
// TDM bus plus the reassembled pair outputs of the receive demux.
interface demux_1x2_tdm_if
  import demux_1x2_tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic             err_clr;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             pair_valid;
  logic             Sel_out;
  logic             sync_err;
  logic [CNT_W-1:0] pair_cnt;

  modport master (
    output din, din_valid, sync, err_clr,
    input  a_out, b_out, pair_valid, Sel_out, sync_err, pair_cnt
  );

  modport slave (
    input  din, din_valid, sync, err_clr,
    output a_out, b_out, pair_valid, Sel_out, sync_err, pair_cnt
  );
endinterface

// File: rtl/demux_1x2_tdm.sv
// Splits an alternating a/b TDM word stream back into registered (a, b) pairs,
// with a sticky framing-error flag and a wrapping completed-pair counter.
module demux_1x2_tdm
  import demux_1x2_tdm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  demux_1x2_tdm_if.slave   bus
);
  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_hold;
  logic             take_a, take_b, frame_err;

  // Any sync-tagged word is a fresh channel-a word, whatever state we are in.
  assign take_a    = bus.din_valid & bus.sync;
  assign take_b    = bus.din_valid & ~bus.sync & (state == EXP_B);
  assign frame_err = bus.din_valid & ((bus.sync & (state == EXP_B)) |
                                      (~bus.sync & (state == EXP_A)));

  always_comb begin
    state_nxt = state;
    if (bus.din_valid) begin
      case (state)
        HUNT:    if (bus.sync) state_nxt = EXP_B;
        EXP_B:   if (!bus.sync) state_nxt = EXP_A;
        EXP_A:   state_nxt = bus.sync ? EXP_B : HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      a_hold         <= '0;
      bus.a_out      <= '0;
      bus.b_out      <= '0;
      bus.pair_valid <= 1'b0;
      bus.Sel_out    <= 1'b0;
      bus.sync_err   <= 1'b0;
      bus.pair_cnt   <= '0;
    end else begin
      state          <= state_nxt;
      bus.Sel_out    <= (state_nxt == EXP_B);
      bus.pair_valid <= take_b;
      if (take_a) a_hold <= bus.din;
      if (take_b) begin
        bus.a_out    <= a_hold;
        bus.b_out    <= bus.din;
        bus.pair_cnt <= bus.pair_cnt + CNT_W'(1);
      end
      // A new error beats a simultaneous clear.
      if (frame_err)        bus.sync_err <= 1'b1;
      else if (bus.err_clr) bus.sync_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_demux_1x2_tdm.sv
// Randomized + directed scoreboard bench for demux_1x2_tdm (CNT_W=2 to exercise wrap).
module tb_demux_1x2_tdm;
  localparam int W = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic          pv;
    logic          sel;
    logic          err;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] cnt;
  } stat_t;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] cnt;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1x2_tdm_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  demux_1x2_tdm #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  stat_t exp_q[$];
  pair_t pair_q[$];

  // Reference model: "holding an a word" and "a pair just finished" describe the framing.
  bit           m_has_a, m_after_pair, m_err;
  logic [W-1:0] m_a, m_ao, m_bo;
  int           m_pairs;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_has_a = 0; m_after_pair = 0; m_err = 0;
    m_a = '0; m_ao = '0; m_bo = '0; m_pairs = 0;
    exp_q.delete();
    pair_q.delete();
  endfunction

  function automatic void model_step(bit v, bit s, logic [W-1:0] d, bit clr);
    stat_t st;
    pair_t p;
    bit pv = 0;
    if (clr) m_err = 0;
    if (v) begin
      if (s) begin
        if (m_has_a) m_err = 1;
        m_has_a = 1; m_a = d; m_after_pair = 0;
      end else if (m_has_a) begin
        m_pairs++;
        m_ao = m_a; m_bo = d;
        p.a = m_a; p.b = d; p.cnt = CW'(m_pairs % (1 << CW));
        pair_q.push_back(p);
        pv = 1; m_has_a = 0; m_after_pair = 1;
      end else if (m_after_pair) begin
        m_err = 1; m_after_pair = 0;
      end
    end
    st.pv = pv; st.sel = m_has_a; st.err = m_err;
    st.a = m_ao; st.b = m_bo; st.cnt = CW'(m_pairs % (1 << CW));
    exp_q.push_back(st);
  endfunction

  task automatic drive(bit v, bit s, logic [W-1:0] d, bit clr);
    @(negedge clk);
    bus.din_valid = v; bus.sync = s; bus.din = d; bus.err_clr = clr;
    model_step(v, s, d, clr);
  endtask

  // Idle cycles carry junk on din/sync to show they are ignored.
  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 1'($urandom), 4'($urandom), 0);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_a"}, 32'(bus.a_out), 0);
    chk({nm, "_b"}, 32'(bus.b_out), 0);
    chk({nm, "_pv"}, 32'(bus.pair_valid), 0);
    chk({nm, "_sel"}, 32'(bus.Sel_out), 0);
    chk({nm, "_err"}, 32'(bus.sync_err), 0);
    chk({nm, "_cnt"}, 32'(bus.pair_cnt), 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    bus.din_valid = 0; bus.sync = 0; bus.err_clr = 0;
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rel_sel", 32'(bus.Sel_out), 0);
  endtask

  // Monitor: one expected status per driven cycle, one expected pair per pair_valid.
  initial begin
    stat_t st;
    pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        st = exp_q.pop_front();
        chk("pair_valid", 32'(bus.pair_valid), 32'(st.pv));
        chk("Sel_out", 32'(bus.Sel_out), 32'(st.sel));
        chk("sync_err", 32'(bus.sync_err), 32'(st.err));
        chk("a_out_hold", 32'(bus.a_out), 32'(st.a));
        chk("b_out_hold", 32'(bus.b_out), 32'(st.b));
        chk("pair_cnt", 32'(bus.pair_cnt), 32'(st.cnt));
        if (bus.pair_valid === 1'b1) begin
          if (pair_q.size() == 0) chk("pair_unexpected", 1, 0);
          else begin
            p = pair_q.pop_front();
            chk("pair_a", 32'(bus.a_out), 32'(p.a));
            chk("pair_b", 32'(bus.b_out), 32'(p.b));
            chk("pair_cnt_at_pv", 32'(bus.pair_cnt), 32'(p.cnt));
          end
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    bus.din = '0; bus.din_valid = 0; bus.sync = 0; bus.err_clr = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk_all_zero("por");
    rst = 1'b0;
    #1 chk("por_rel_sel", 32'(bus.Sel_out), 0);

    // nominal pair
    drive(1, 1, 4'b0100, 0); drive(1, 0, 4'b1001, 0); idle(2);
    // stall between a and b
    drive(1, 1, 4'h5, 0); idle(3); drive(1, 0, 4'hA, 0); idle(1);
    // double sync: a repeated, resync to the later a
    drive(1, 1, 4'h4, 0); drive(1, 1, 4'h7, 0); drive(1, 0, 4'h9, 0); idle(1);
    drive(0, 0, 4'h0, 1);
    // missing a after a completed pair, then clear
    drive(1, 1, 4'h2, 0); drive(1, 0, 4'h6, 0); drive(1, 0, 4'h3, 0);
    idle(1); drive(0, 0, 4'h0, 1); idle(1);
    // non-sync word while hunting: dropped without error
    drive(1, 0, 4'hE, 0); idle(1);
    // wrap: 5 back-to-back pairs
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 4'(i), 0); drive(1, 0, 4'(15 - i), 0);
    end
    idle(1);
    // error and clear in the same cycle: set wins
    drive(1, 1, 4'h1, 0); drive(1, 1, 4'h8, 1); drive(1, 0, 4'hC, 0); idle(1);
    drive(0, 0, 4'h0, 1);
    // reset mid-pair discards the captured a
    drive(1, 1, 4'hB, 0);
    mid_reset();
    drive(1, 0, 4'hD, 0); drive(1, 1, 4'h3, 0); drive(1, 0, 4'h5, 0); idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(3, 0) != 0), ($urandom_range(2, 0) == 0) ? 1'b0 : 1'($urandom),
            4'($urandom), ($urandom_range(7, 0) == 0));
    mid_reset();
    for (int i = 0; i < 200; i++)
      drive(1'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(9, 0) == 0));
    idle(2);

    wait_cyc = 0;
    while ((exp_q.size() > 0) && (wait_cyc < 10)) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("drain_status", 32'(exp_q.size()), 0);
    chk("drain_pairs", 32'(pair_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
